exu_mdu_iter: RTL and testbench
===============================

Name: exu_mdu_iter

Overview:
Parametrised, multi-cycle RV64M multiply/divide unit. It is the sequential successor to the single-cycle combinational mult/div/rem path in the execute stage. It sits beside the single-cycle ALU in EXU and takes operands already selected by the EXU source muxes. It replaces `*`, `/` and `%` operators with a shared iterative shift-add/restoring-divide datapath and a valid/ready handshake, so EXU can stall on it.

Parameters:
- W, 64, datapath width; must be even and at least 8. The word ("W") ops act on the low W/2 bits.
- OPW, 4, width of the op select. Must equal MDU_OP_WIDTH from the package.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  request valid
- o_ready  out  1  unit can accept; high only in IDLE
- i_op  in  OPW  operation (mdu_pkg encoding)
- i_src1  in  W  operand 1 (rs1)
- i_src2  in  W  operand 2 (rs2)
- i_flush  in  1  kill the in-flight op
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts the result
- o_res  out  W  result

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (sync, active-high): state=IDLE, o_valid=0, o_res=0, iteration counter=0. o_ready=1 from the first cycle after reset.
- IDLE, on i_valid && o_ready:
  - latch op, operands and sign info;
  - load the counter with N (N=W for full-width ops, N=W/2 for word ops);
  - go to CALC.
- CALC: one bit per cycle (multiply: shift-add; divide: restoring). Decrement the counter. When the counter reaches 1, the next state is DONE.
- Latency: accept edge t0 → CALC for cycles t0+1..t0+N → o_valid=1 from t0+N+1.
- DONE: hold o_valid and o_res stable until i_ready. On o_valid && i_ready go to IDLE, with o_valid=0 in the next cycle. There is no back-to-back accept in the same cycle as result handoff.
- Signedness:
  - Operate on magnitudes.
  - MUL, MULH, DIV, REM: both operands signed. MULHSU: src1 signed, src2 unsigned. Unsigned ops: both unsigned.
  - Product sign = XOR of the effective signs. Quotient sign = XOR of the signs. Remainder takes the dividend's sign.
  - Negate in DONE entry (two's complement).
- Product is 2W bits. MUL and MULW return the low half; MULH, MULHSU and MULHU return the high half.
- Word ops: operate on the low W/2 bits, signed or unsigned per op. The result's low W/2 bits are sign-extended from bit W/2-1 to W, including DIVUW and REMUW.
- Divide by zero: quotient = all ones (for word ops, all ones in the low half, then sign-extended). Remainder = dividend, i.e. the unmodified low-half or full value, sign-extended for word ops.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- Illegal op code: N forced to 1, result 0.
- Flush:
  - i_flush in CALC or DONE → IDLE next cycle; o_valid=0, result discarded.
  - i_flush in the same cycle as i_valid in IDLE → request not accepted.
  - Reset overrides flush.
- i_src and i_op are ignored outside the accept cycle.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: divide-by-zero, signed overflow, and multiply with either operand equal to 0 skip CALC. DONE is entered at t0+1, with the same result values as above.
- Undefined: these cases run the full N iterations and produce identical results; latency is fixed per op width.

Decomposition:
- Package mdu_pkg holds:
  - MDU_OP_WIDTH=4;
  - an enum of ops: MUL=0, MULH=1, MULHSU=2, MULHU=3, MULW=4, DIV=5, DIVU=6, DIVW=7, DIVUW=8, REM=9, REMU=10, REMW=11, REMUW=12;
  - helper functions is_word(op), is_div(op), is_rem(op), src1_signed(op), src2_signed(op).
- One sub-module, mdu_iter_core: the shared 2W-bit partial-remainder/product shift register plus adder/subtractor, with one-step enable. The top holds the FSM, handshake, sign fixup and special cases.

Test Plan:
1. MUL, src1=0xFFFF_FFFF_FFFF_FFFF (-1), src2=7 → o_res=0xFFFF_FFFF_FFFF_FFF9, o_valid at t0+65; MULHU on the same operands → 0x6.
2. DIVW, src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF → o_res=0xFFFF_FFFF_8000_0000 at t0+33; REMW on the same operands → 0.
3. DIVU, src2=0, src1=0x1234 → o_res=all ones; REMU → 0x1234; with MDU_EARLY_OUT_EN, valid at t0+1.
4. REM, src1=-7, src2=2 → o_res=-1 (0xFFFF_FFFF_FFFF_FFFF); MULHSU, src1=-1, src2=2 → o_res=0xFFFF_FFFF_FFFF_FFFF.
5. Backpressure: hold i_ready=0 for 5 cycles in DONE → o_res stable, o_ready=0; release → o_ready=1 in the next cycle.
6. Flush mid-CALC (cycle t0+10) → o_valid never rises, o_ready=1 at t0+11. Also assert i_rst mid-CALC → all outputs at reset values in the next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encoding and op-class helpers shared by the iterative multiply/divide unit.
package mdu_pkg;

   localparam int MDU_OP_WIDTH = 4;

   typedef enum logic [MDU_OP_WIDTH-1:0] {
      OP_MUL    = 4'd0,
      OP_MULH   = 4'd1,
      OP_MULHSU = 4'd2,
      OP_MULHU  = 4'd3,
      OP_MULW   = 4'd4,
      OP_DIV    = 4'd5,
      OP_DIVU   = 4'd6,
      OP_DIVW   = 4'd7,
      OP_DIVUW  = 4'd8,
      OP_REM    = 4'd9,
      OP_REMU   = 4'd10,
      OP_REMW   = 4'd11,
      OP_REMUW  = 4'd12
   } mdu_op_e;

   function automatic logic is_legal(input logic [MDU_OP_WIDTH-1:0] op);
      return op <= OP_REMUW;
   endfunction

   function automatic logic is_word(input logic [MDU_OP_WIDTH-1:0] op);
      return op == OP_MULW || op == OP_DIVW || op == OP_DIVUW || op == OP_REMW || op == OP_REMUW;
   endfunction

   function automatic logic is_div(input logic [MDU_OP_WIDTH-1:0] op);
      return op == OP_DIV || op == OP_DIVU || op == OP_DIVW || op == OP_DIVUW;
   endfunction

   function automatic logic is_rem(input logic [MDU_OP_WIDTH-1:0] op);
      return op == OP_REM || op == OP_REMU || op == OP_REMW || op == OP_REMUW;
   endfunction

   function automatic logic src1_signed(input logic [MDU_OP_WIDTH-1:0] op);
      return op == OP_MUL || op == OP_MULH || op == OP_MULHSU || op == OP_MULW ||
             op == OP_DIV || op == OP_DIVW || op == OP_REM || op == OP_REMW;
   endfunction

   function automatic logic src2_signed(input logic [MDU_OP_WIDTH-1:0] op);
      return op == OP_MUL || op == OP_MULH || op == OP_MULW ||
             op == OP_DIV || op == OP_DIVW || op == OP_REM || op == OP_REMW;
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: shared 2W-bit shift register with one adder/subtractor, one bit per step.
// Multiply shifts right (LSB-first shift-add); divide shifts left (MSB-first restoring).
module mdu_iter_core #(
   parameter int W = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic           step,
   input  logic           div,
   input  logic [2*W-1:0] load_acc,
   input  logic [W-1:0]   load_opnd,
   output logic [2*W-1:0] acc_next
);

   logic [2*W-1:0] acc;
   logic [W-1:0]   opnd;
   logic [W:0]     sum;
   logic [W:0]     rem_sh;
   logic [W-1:0]   diff;

   always_comb begin
      sum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
      rem_sh = acc[2*W-1:W-1];
      // when the trial succeeds the true difference is below opnd, so W bits suffice
      diff   = rem_sh[W-1:0] - opnd;
      if (div) begin
         if (rem_sh >= {1'b0, opnd}) acc_next = {diff, acc[W-2:0], 1'b1};
         else                        acc_next = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
      end else begin
         acc_next = {sum, acc[W-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         opnd <= '0;
      end else if (load) begin
         acc  <= load_acc;
         opnd <= load_opnd;
      end else if (step) begin
         acc  <= acc_next;
      end
   end

endmodule

// File: rtl/exu_mdu_iter.sv
// exu_mdu_iter: iterative RV64M multiply/divide with valid/ready handshake and flush.
// Optional MDU_EARLY_OUT_EN: zero-operand multiply, divide-by-zero and MIN/-1 skip CALC.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | iterating, one result bit per cycle
// DONE  | result held on o_res until consumed
module exu_mdu_iter
   import mdu_pkg::*;
#(
   parameter int W   = 64,
   parameter int OPW = 4
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic [OPW-1:0] i_op,
   input  logic [W-1:0]   i_src1,
   input  logic [W-1:0]   i_src2,
   input  logic           i_flush,
   output logic           o_valid,
   input  logic           i_ready,
   output logic [W-1:0]   o_res
);

   localparam int H  = W / 2;
   localparam int CW = $clog2(W) + 1;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [H-1:0] MIN_H = {1'b1, {(H-1){1'b0}}};
   localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

   logic [1:0]     state;
   logic [CW-1:0]  cnt;
   logic [OPW-1:0] op_q;
   logic           neg1_q, neg2_q, div0_q, ovf_q, mdiv_q;
   logic [W-1:0]   src1_q;

   logic           accept, word_in, mdiv_in, neg1_in, neg2_in, div0_in, ovf_in, early;
   logic [H-1:0]   m1h, m2h;
   logic [W-1:0]   mag1, mag2;
   logic [2*W-1:0] load_acc, acc_next;
   logic [CW-1:0]  n_load;

   // Turns the unsigned magnitude result into the architectural value, including special cases.
   function automatic logic [W-1:0] fix_res(input logic [OPW-1:0] op, input logic neg1,
                                            input logic neg2, input logic div0, input logic ovf,
                                            input logic [W-1:0] src1, input logic [2*W-1:0] acc);
      logic [2*W-1:0] p2;
      logic [W-1:0]   v;
      p2 = (neg1 ^ neg2) ? -acc : acc;
      if (!(is_div(op) || is_rem(op)))
         v = is_word(op) ? p2[H +: W] : ((op == OP_MUL) ? p2[W-1:0] : p2[2*W-1:W]);
      else if (div0)
         v = is_div(op) ? {W{1'b1}} : src1;
      else if (ovf)
         v = is_div(op) ? (is_word(op) ? {{(W-H){1'b0}}, MIN_H} : MIN_W) : {W{1'b0}};
      else if (is_div(op))
         v = (neg1 ^ neg2) ? -acc[W-1:0] : acc[W-1:0];
      else
         v = neg1 ? -acc[2*W-1:W] : acc[2*W-1:W];
      if (!is_legal(op)) return '0;
      return is_word(op) ? {{(W-H){v[H-1]}}, v[H-1:0]} : v;
   endfunction

   always_comb begin
      word_in = is_word(i_op);
      mdiv_in = is_div(i_op) || is_rem(i_op);
      neg1_in = src1_signed(i_op) && (word_in ? i_src1[H-1] : i_src1[W-1]);
      neg2_in = src2_signed(i_op) && (word_in ? i_src2[H-1] : i_src2[W-1]);
      m1h     = neg1_in ? -i_src1[H-1:0] : i_src1[H-1:0];
      m2h     = neg2_in ? -i_src2[H-1:0] : i_src2[H-1:0];
      mag1    = word_in ? {{(W-H){1'b0}}, m1h} : (neg1_in ? -i_src1 : i_src1);
      mag2    = word_in ? {{(W-H){1'b0}}, m2h} : (neg2_in ? -i_src2 : i_src2);
      div0_in = word_in ? (i_src2[H-1:0] == '0) : (i_src2 == '0);
      ovf_in  = src1_signed(i_op) && mdiv_in &&
                (word_in ? (i_src1[H-1:0] == MIN_H && i_src2[H-1:0] == '1)
                         : (i_src1 == MIN_W && i_src2 == '1));
      // word divides start with the dividend in the upper half so W/2 steps consume it
      load_acc = (mdiv_in && word_in) ? {{W{1'b0}}, mag1[H-1:0], {H{1'b0}}}
                                      : {{W{1'b0}}, mag1};
      n_load  = !is_legal(i_op) ? CW'(1) : (word_in ? CW'(H) : CW'(W));
      accept  = (state == ST_IDLE) && i_valid && !i_flush;
`ifdef MDU_EARLY_OUT_EN
      early   = is_legal(i_op) && (mdiv_in ? (div0_in || ovf_in) : (mag1 == '0 || mag2 == '0));
`else
      early   = 1'b0;
`endif
   end

   assign o_ready = (state == ST_IDLE);
   assign o_valid = (state == ST_DONE);

   mdu_iter_core #(.W(W)) u_core (
      .clk       (i_clk),
      .rst       (i_rst),
      .load      (accept),
      .step      (state == ST_CALC),
      .div       (mdiv_q),
      .load_acc  (load_acc),
      .load_opnd (mag2),
      .acc_next  (acc_next)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         o_res  <= '0;
         op_q   <= '0;
         neg1_q <= 1'b0;
         neg2_q <= 1'b0;
         div0_q <= 1'b0;
         ovf_q  <= 1'b0;
         mdiv_q <= 1'b0;
         src1_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               op_q   <= i_op;
               neg1_q <= neg1_in;
               neg2_q <= neg2_in;
               div0_q <= div0_in;
               ovf_q  <= ovf_in;
               mdiv_q <= mdiv_in;
               src1_q <= i_src1;
               if (early) begin
                  cnt   <= '0;
                  state <= ST_DONE;
                  o_res <= fix_res(i_op, neg1_in, neg2_in, div0_in, ovf_in, i_src1, '0);
               end else begin
                  cnt   <= n_load;
                  state <= ST_CALC;
               end
            end
            ST_CALC: if (i_flush) begin
               cnt   <= '0;
               state <= ST_IDLE;
            end else begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= ST_DONE;
                  o_res <= fix_res(op_q, neg1_q, neg2_q, div0_q, ovf_q, src1_q, acc_next);
               end
            end
            ST_DONE: if (i_flush || i_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exu_mdu_iter.sv
// tb_exu_mdu_iter: directed self-checking bench for the iterative multiply/divide unit.
module tb_exu_mdu_iter;
   import mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        i_clk, i_rst, i_valid, o_ready, i_flush, o_valid, i_ready;
   logic [3:0]  i_op;
   logic [63:0] i_src1, i_src2, o_res;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
      string       name;
   } vec_t;

   exu_mdu_iter #(.W(64), .OPW(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
      .i_src1(i_src1), .i_src2(i_src2), .i_flush(i_flush), .o_valid(o_valid),
      .i_ready(i_ready), .o_res(o_res)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #2ms;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // Issues one request and waits for o_valid; lat is the cycle count with the accept cycle as 1.
   task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
      i_op = op; i_src1 = a; i_src2 = b; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_op = 4'd6; i_src1 = 64'hDEAD_BEEF_0BAD_F00D; i_src2 = 64'h3;
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
         if (o_valid) begin
            lat = k;
            break;
         end
         @(posedge i_clk); #1;
      end
      res = o_res;
   endtask

   task automatic release_res();
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
   endtask

   task automatic run_table(input vec_t v[$]);
      logic [63:0] res;
      int lat;
      foreach (v[i]) begin
         do_op(v[i].op, v[i].a, v[i].b, res, lat);
         checks++;
         if (res !== v[i].exp) begin
            failures++;
            $display("FAIL %s result got=%h exp=%h", v[i].name, res, v[i].exp);
         end
         checks++;
         if (lat != v[i].lat) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", v[i].name, lat, v[i].lat);
         end
         release_res();
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      checks++;
      if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
      checks++;
      if (o_res !== 64'h0) begin failures++; $display("FAIL reset_res got=%h exp=0", o_res); end
   endtask

   task automatic test_mul();
      vec_t v[$];
      v.push_back('{OP_MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'h7, 64'hFFFF_FFFF_FFFF_FFF9, 65, "mul_neg"});
      v.push_back('{OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h7, 64'h6, 65, "mulhu"});
      v.push_back('{OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 65, "mulh_negneg"});
      v.push_back('{OP_MULHU,  64'h8000_0000_0000_0000, 64'h4, 64'h2, 65, "mulhu_big"});
      v.push_back('{OP_MULW,   64'h0000_0000_7FFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw_sext"});
      v.push_back('{OP_MUL,    64'h0, 64'h55, 64'h0, EARLY ? 1 : 65, "mul_zero"});
      run_table(v);
   endtask

   task automatic test_div();
      vec_t v[$];
      v.push_back('{OP_DIVW,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, EARLY ? 1 : 33, "divw_ovf"});
      v.push_back('{OP_REMW,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, EARLY ? 1 : 33, "remw_ovf"});
      v.push_back('{OP_DIVU,  64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, EARLY ? 1 : 65, "divu_zero"});
      v.push_back('{OP_REMU,  64'h1234, 64'h0, 64'h1234, EARLY ? 1 : 65, "remu_zero"});
      v.push_back('{OP_DIV,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div_neg"});
      v.push_back('{OP_REM,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 65, "rem_pos"});
      v.push_back('{OP_DIVUW, 64'h0000_0001_FFFF_FFFF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 33, "divuw_sext"});
      v.push_back('{OP_REMUW, 64'h0000_0001_0000_0007, 64'h0000_0005_0000_0005, 64'h2, 33, "remuw"});
      v.push_back('{OP_REMW,  64'h0000_0000_8000_0005, 64'h0, 64'hFFFF_FFFF_8000_0005, EARLY ? 1 : 33, "remw_zero"});
      v.push_back('{OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, EARLY ? 1 : 65, "div_ovf"});
      run_table(v);
   endtask

   task automatic test_signed();
      vec_t v[$];
      v.push_back('{OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_negdiv"});
      v.push_back('{OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "mulhsu_neg"});
      v.push_back('{OP_MULHSU, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 65, "mulhsu_uns2"});
      run_table(v);
   endtask

   task automatic test_illegal();
      vec_t v[$];
      v.push_back('{4'd13, 64'h1234, 64'h5678, 64'h0, 2, "illegal13"});
      v.push_back('{4'd15, 64'hFFFF, 64'h3, 64'h0, 2, "illegal15"});
      run_table(v);
   endtask

   task automatic test_backpressure();
      logic [63:0] res;
      int lat;
      int bad;
      do_op(OP_DIVU, 64'd100, 64'd3, res, lat);
      checks++;
      if (res !== 64'd33) begin failures++; $display("FAIL bp_result got=%h exp=%h", res, 64'd33); end
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge i_clk); #1;
         if (o_res !== 64'd33 || o_ready !== 1'b0 || o_valid !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
      release_res();
      checks++;
      if (o_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", o_ready); end
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_after got=%b exp=0", o_valid); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] res;
      int lat;
      do_op(OP_MUL, 64'd6, 64'd7, res, lat);
      checks++;
      if (res !== 64'd42) begin failures++; $display("FAIL b2b_mul got=%h exp=%h", res, 64'd42); end
      release_res();
      do_op(OP_DIVU, 64'd42, 64'd6, res, lat);
      checks++;
      if (res !== 64'd7) begin failures++; $display("FAIL b2b_div got=%h exp=%h", res, 64'd7); end
      checks++;
      if (lat != 65) begin failures++; $display("FAIL b2b_div_lat got=%0d exp=65", lat); end
      release_res();
   endtask

   task automatic test_flush();
      logic [63:0] res;
      int lat;
      int highs;
      // flush together with valid in IDLE must not start a request
      i_op = OP_MUL; i_src1 = 64'd3; i_src2 = 64'd5; i_valid = 1'b1; i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_flush = 1'b0;
      checks++;
      if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_idle_ready got=%b exp=1", o_ready); end
      i_op = OP_MUL; i_src1 = 64'd3; i_src2 = 64'd5; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (9) @(posedge i_clk);
      #1;
      checks++;
      if (o_ready !== 1'b0) begin failures++; $display("FAIL flush_calc_busy got=%b exp=0", o_ready); end
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      checks++;
      if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", o_ready); end
      highs = 0;
      for (int k = 0; k < 70; k++) begin
         if (o_valid) highs++;
         @(posedge i_clk); #1;
      end
      checks++;
      if (highs != 0) begin failures++; $display("FAIL flush_no_valid high_cycles=%0d exp=0", highs); end
      do_op(OP_MUL, 64'd11, 64'd13, res, lat);
      checks++;
      if (res !== 64'd143) begin failures++; $display("FAIL flush_recover got=%h exp=%h", res, 64'd143); end
      release_res();
   endtask

   task automatic test_reset_mid();
      i_op = OP_DIVU; i_src1 = 64'd1000; i_src2 = 64'd7; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (5) @(posedge i_clk);
      #1 i_rst = 1'b1; i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0; i_flush = 1'b0;
      checks++;
      if (o_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", o_ready); end
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", o_valid); end
      checks++;
      if (o_res !== 64'h0) begin failures++; $display("FAIL rstmid_res got=%h exp=0", o_res); end
   endtask

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
      i_op = '0; i_src1 = '0; i_src2 = '0;
      test_reset();
      test_mul();
      test_div();
      test_signed();
      test_illegal();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
